// File: rtl/a_seq_pkg.sv
// Shared types and helpers for the A-line sequence generator.
package a_seq_pkg;

  localparam int unsigned CntWDef = 8;
  localparam int unsigned FrmWDef = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPh1Hi = 3'd1,
    StPh2Lo = 3'd2,
    StPh3Hi = 3'd3,
    StPh4Lo = 3'd4,
    StFin   = 3'd5
  } state_e;

  // A programmed length of zero still yields a one-cycle phase.
  function automatic int unsigned phase_len(input int unsigned raw);
    return (raw == 0) ? 1 : raw;
  endfunction

endpackage

// File: rtl/a_phase_timer.sv
// Down-counting phase timer: load with a length, flags the final cycle.
module a_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load length-1 so a phase of N cycles ends when the count reaches zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= len_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/a_seq_gen.sv
// A-line frame transmitter with cycle-exact F/G response checking.
module a_seq_gen
  import a_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned FRM_W = FrmWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_req_i,
  input  logic             abort_i,
  input  logic [FRM_W-1:0] num_frames_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic             f_i,
  input  logic             g_i,
  output logic             a_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [FRM_W-1:0] frames_sent_o
);

  state_e           state_q;
  logic             a_q, done_q, error_q, first_q;
  logic [FRM_W-1:0] nf_q, frames_sent_q, fs_inc;
  logic [CNT_W-1:0] hi_len_q, lo_len_q;
  logic [1:0]       f_cnt_q, f_cnt_d, g_cnt_q, g_cnt_d;
  logic             tmr_load, tmr_last, chk_err;
  logic [CNT_W-1:0] tmr_len;

  assign fs_inc = frames_sent_q + 1'b1;

  a_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .last_o (tmr_last)
  );

  // Timer reload whenever the FSM enters a new phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_len  = hi_len_q;
    unique case (state_q)
      StIdle: begin
        if (start_req_i && num_frames_i != '0) begin
          tmr_load = 1'b1;
          tmr_len  = CNT_W'(phase_len(32'(high_len_i)));
        end
      end
      StPh1Hi: if (tmr_last) begin tmr_load = 1'b1; tmr_len = lo_len_q; end
      StPh2Lo: if (tmr_last) begin tmr_load = 1'b1; tmr_len = hi_len_q; end
      StPh3Hi: if (tmr_last) begin tmr_load = 1'b1; tmr_len = lo_len_q; end
      StPh4Lo: if (tmr_last && fs_inc != nf_q) begin tmr_load = 1'b1; tmr_len = hi_len_q; end
      default: ;
    endcase
  end

  // F may only fire on the first PH3 cycle and G on the first PH4 cycle, each exactly once.
  always_comb begin
    f_cnt_d = f_cnt_q;
    g_cnt_d = g_cnt_q;
    chk_err = 1'b0;
    if (f_i && f_cnt_q != 2'd3) f_cnt_d = f_cnt_q + 2'd1;
    if (g_i && g_cnt_q != 2'd3) g_cnt_d = g_cnt_q + 2'd1;
    if (f_i && !(state_q == StPh3Hi && first_q)) chk_err = 1'b1;
    if (g_i && !(state_q == StPh4Lo && first_q)) chk_err = 1'b1;
    if (state_q == StPh3Hi && tmr_last && f_cnt_d != 2'd1) chk_err = 1'b1;
    if (state_q == StPh4Lo && tmr_last && g_cnt_d != 2'd1) chk_err = 1'b1;
  end

  // Main FSM with registered line, done, error and frame counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      a_q           <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      first_q       <= 1'b0;
      nf_q          <= '0;
      frames_sent_q <= '0;
      hi_len_q      <= '0;
      lo_len_q      <= '0;
      f_cnt_q       <= '0;
      g_cnt_q       <= '0;
    end else if (abort_i) begin
      // Frames_sent and Error deliberately hold across an abort.
      state_q <= StIdle;
      a_q     <= 1'b0;
      done_q  <= 1'b0;
      first_q <= 1'b0;
      f_cnt_q <= '0;
      g_cnt_q <= '0;
    end else begin
      done_q  <= 1'b0;
      first_q <= tmr_load;
      f_cnt_q <= (state_q == StPh3Hi) ? f_cnt_d : '0;
      g_cnt_q <= (state_q == StPh4Lo) ? g_cnt_d : '0;
      if (state_q != StIdle && chk_err) error_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_req_i) begin
            nf_q          <= num_frames_i;
            hi_len_q      <= CNT_W'(phase_len(32'(high_len_i)));
            lo_len_q      <= CNT_W'(phase_len(32'(low_len_i)));
            frames_sent_q <= '0;
            error_q       <= 1'b0;
            if (num_frames_i != '0) begin
              state_q <= StPh1Hi;
              a_q     <= 1'b1;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end
          end
        end
        StPh1Hi: if (tmr_last) begin state_q <= StPh2Lo; a_q <= 1'b0; end
        StPh2Lo: if (tmr_last) begin state_q <= StPh3Hi; a_q <= 1'b1; end
        StPh3Hi: if (tmr_last) begin state_q <= StPh4Lo; a_q <= 1'b0; end
        StPh4Lo: begin
          if (tmr_last) begin
            frames_sent_q <= fs_inc;
            if (fs_inc == nf_q) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPh1Hi;
              a_q     <= 1'b1;
            end
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a_o           = a_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign frames_sent_o = frames_sent_q;

endmodule
